// File: rtl/f32m_alu_seq.sv
// GF(3^2M) arithmetic unit: MUL/SQR/ADD/SUB with start/busy/done.
// One serial GF(3^M) multiplier is time-shared across sub-products.
module f32m_alu_seq #(
  parameter int M = 97,
  parameter logic [2*M+1:0] PX =
    196'h4000000000000000000000000000000000000000001000002
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_start,
  input  logic [1:0]     i_op,
  input  logic [4*M-1:0] i_a,
  input  logic [4*M-1:0] i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [4*M-1:0] o_c
);

  localparam int W  = 2 * M;
  localparam int CW = $clog2(M + 1);
  localparam logic [W-1:0] PL = PX[W-1:0];

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SQR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_FIN
  } state_t;

  function automatic logic [1:0] f_cadd(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [W-1:0] f_add(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = f_cadd(x[2*i +: 2], y[2*i +: 2]);
    return r;
  endfunction

  // Negation mod 3 just swaps the two code bits (1 <-> 2).
  function automatic logic [W-1:0] f_neg(
    input logic [W-1:0] x
  );
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = {x[2*i], x[2*i+1]};
    return r;
  endfunction

  function automatic logic [W-1:0] f_sub(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    return f_add(x, f_neg(y));
  endfunction

  function automatic logic [W-1:0] f_scl(
    input logic [1:0]   s,
    input logic [W-1:0] x
  );
    logic [W-1:0] r;
    case (s)
      2'd1:    r = x;
      2'd2:    r = f_neg(x);
      default: r = '0;
    endcase
    return r;
  endfunction

  // x * t mod PX: shift up one coefficient, fold the overflow back.
  function automatic logic [W-1:0] f_mulx(
    input logic [W-1:0] x
  );
    return f_sub({x[W-3:0], 2'b00}, f_scl(x[W-1:W-2], PL));
  endfunction

  state_t         r_state;
  logic [1:0]     r_op;
  logic [W-1:0]   r_a0, r_a1, r_b0, r_b1;
  logic [W-1:0]   r_p0, r_p1;
  logic [1:0]     r_k;
  logic           r_mrst;
  logic           r_busy;
  logic           r_done;
  logic [4*M-1:0] r_c;

  logic [W-1:0]   r_m_a, r_m_b, r_m_acc;
  logic [CW-1:0]  r_m_cnt;
  logic           r_m_done;

  logic           w_m_rst;
  logic [W-1:0]   w_mx_a, w_mx_b;
  logic [W-1:0]   w_c0, w_c1;
  logic [W-1:0]   w_a0, w_a1, w_b0, w_b1;
  logic [W-1:0]   w_as0, w_as1;
  logic           w_last;

  assign w_a0 = i_a[W-1:0];
  assign w_a1 = i_a[2*W-1:W];
  assign w_b0 = i_b[W-1:0];
  assign w_b1 = i_b[2*W-1:W];

  assign w_as0 = i_op[0] ? f_sub(w_a0, w_b0) : f_add(w_a0, w_b0);
  assign w_as1 = i_op[0] ? f_sub(w_a1, w_b1) : f_add(w_a1, w_b1);

  assign w_m_rst = reset | r_mrst;
  assign w_last  = (r_op == OP_MUL) ? (r_k == 2'd2) : (r_k == 2'd1);

  // Select the operands of sub-product k for the shared multiplier.
  always_comb begin
    w_mx_a = r_a0;
    w_mx_b = r_b0;
    if (r_op == OP_SQR) begin
      if (r_k == 2'd0) begin
        w_mx_a = f_add(r_a0, r_a1);
        w_mx_b = f_sub(r_a0, r_a1);
      end else begin
        w_mx_a = r_a0;
        w_mx_b = r_a1;
      end
    end else if (r_k == 2'd1) begin
      w_mx_a = r_a1;
      w_mx_b = r_b1;
    end else if (r_k == 2'd2) begin
      w_mx_a = f_add(r_a0, r_a1);
      w_mx_b = f_add(r_b0, r_b1);
    end
  end

  // Combine stored products with the one just finishing in the multiplier.
  always_comb begin
    if (r_op == OP_SQR) begin
      w_c0 = r_p0;
      w_c1 = f_neg(r_m_acc);
    end else begin
      w_c0 = f_sub(r_p0, r_p1);
      w_c1 = f_sub(f_sub(r_m_acc, r_p0), r_p1);
    end
  end

  // Serial GF(3^M) multiplier, Horner over b from the top coefficient.
  always_ff @(posedge clk) begin
    if (w_m_rst) begin
      r_m_acc  <= '0;
      r_m_a    <= w_mx_a;
      r_m_b    <= w_mx_b;
      r_m_cnt  <= CW'(M);
      r_m_done <= 1'b0;
    end else if (r_m_cnt != '0) begin
      r_m_acc <= f_add(f_mulx(r_m_acc),
                       f_scl(r_m_b[W-1:W-2], r_m_a));
      r_m_b   <= r_m_b << 2;
      r_m_cnt <= r_m_cnt - 1'b1;
      if (r_m_cnt == CW'(1)) r_m_done <= 1'b1;
    end
  end

  // Control FSM: accept, sequence sub-products, publish result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a0    <= '0;
      r_a1    <= '0;
      r_b0    <= '0;
      r_b1    <= '0;
      r_p0    <= '0;
      r_p1    <= '0;
      r_k     <= '0;
      r_mrst  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_c     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_k <= '0;
          if (i_start) begin
            r_op   <= i_op;
            r_a0   <= w_a0;
            r_a1   <= w_a1;
            r_b0   <= w_b0;
            r_b1   <= w_b1;
            r_busy <= 1'b1;
            if (i_op[1]) begin
              r_c     <= {w_as1, w_as0};
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_mrst  <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_mrst  <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_m_done) begin
            if (w_last) begin
              r_c     <= {w_c1, w_c0};
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              if (r_k == 2'd0) r_p0 <= r_m_acc;
              else             r_p1 <= r_m_acc;
              r_k     <= r_k + 2'd1;
              r_mrst  <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_k     <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_c    = r_c;

endmodule

// File: tb/tb_f32m_alu_seq.sv
// Randomized bench for f32m_alu_seq.
// Reference: schoolbook GF(3^M) arithmetic on integer coefficients.
module tb_f32m_alu_seq;

  localparam int M = 97;
  localparam int W = 2 * M;
  localparam logic [2*M+1:0] PX =
    196'h4000000000000000000000000000000000000000001000002;
  localparam int T   = M;
  localparam int LIM = 2000;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           i_start = 1'b0;
  logic [1:0]     i_op = '0;
  logic [4*M-1:0] i_a = '0;
  logic [4*M-1:0] i_b = '0;
  logic           o_busy;
  logic           o_done;
  logic [4*M-1:0] o_c;

  int n_cmp = 0;
  int n_bad = 0;

  f32m_alu_seq #(.M(M), .PX(PX)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_c     (o_c)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] badd(
    input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = 2'((int'(x[2*i +: 2]) + int'(y[2*i +: 2])) % 3);
    return r;
  endfunction

  function automatic logic [W-1:0] bneg(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = 2'((3 - int'(x[2*i +: 2])) % 3);
    return r;
  endfunction

  function automatic logic [W-1:0] bsub(
    input logic [W-1:0] x, input logic [W-1:0] y);
    return badd(x, bneg(y));
  endfunction

  function automatic logic [W-1:0] bmul(
    input logic [W-1:0] x, input logic [W-1:0] y);
    int pr [0:2*M-2];
    logic [2*M+1:0] pv;
    logic [W-1:0] r;
    int cc;
    pv = PX;
    r = '0;
    for (int i = 0; i < 2*M-1; i++) pr[i] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        pr[i+j] += int'(x[2*i +: 2]) * int'(y[2*j +: 2]);
    for (int d = 2*M-2; d >= M; d--) begin
      cc = pr[d] % 3;
      pr[d] = 0;
      if (cc != 0)
        for (int j = 0; j < M; j++)
          pr[d-M+j] += cc * (3 - int'(pv[2*j +: 2]));
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(pr[i] % 3);
    return r;
  endfunction

  function automatic logic [4*M-1:0] ext_ref(
    input logic [1:0] op,
    input logic [4*M-1:0] a, input logic [4*M-1:0] b);
    logic [W-1:0] a0, a1, b0, b1, c0, c1, t;
    a0 = a[W-1:0]; a1 = a[2*W-1:W];
    b0 = b[W-1:0]; b1 = b[2*W-1:W];
    case (op)
      2'd0: begin
        c0 = bsub(bmul(a0, b0), bmul(a1, b1));
        c1 = badd(bmul(a0, b1), bmul(a1, b0));
      end
      2'd1: begin
        t  = bmul(a0, a1);
        c0 = bsub(bmul(a0, a0), bmul(a1, a1));
        c1 = badd(t, t);
      end
      2'd2: begin c0 = badd(a0, b0); c1 = badd(a1, b1); end
      default: begin c0 = bsub(a0, b0); c1 = bsub(a1, b1); end
    endcase
    return {c1, c0};
  endfunction

  function automatic logic [4*M-1:0] rnd_elem();
    logic [4*M-1:0] r;
    r = '0;
    for (int i = 0; i < 2*M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
    if (op == 2'd0) return 3 * (T + 2) + 1;
    if (op == 2'd1) return 2 * (T + 2) + 1;
    return 1;
  endfunction

  // Drive one op; report cycles from start to done, busy coverage, result.
  task automatic do_op(
    input  logic [1:0] op,
    input  logic [4*M-1:0] a, input logic [4*M-1:0] b,
    input  bit spam,
    output int lat, output bit busy_ok, output logic [4*M-1:0] c);
    lat = -1; busy_ok = 1'b1; c = '0;
    @(negedge clk);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    for (int n = 1; n <= LIM; n++) begin
      @(negedge clk);
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      if (o_done === 1'b1) begin lat = n; c = o_c; break; end
      if (spam) begin
        i_start = 1'b1; i_a = rnd_elem(); i_b = rnd_elem();
        i_op = 2'($urandom_range(0, 3));
      end else i_start = 1'b0;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; i_start = 1'b1; i_op = 2'd2;
    i_a = rnd_elem(); i_b = rnd_elem();
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (n == 1) begin reset = 1'b0; i_start = 1'b0; end
      n_cmp++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_c !== '0) begin
        n_bad++;
        $display("FAIL reset[%0d]: busy=%b done=%b c=%h want 0/0/0",
                 n, o_busy, o_done, o_c);
      end
    end
  endtask

  task automatic test_mul();
    logic [4*M-1:0] a, b, c, e;
    int lat; bit bok;
    a = '0; a[1:0] = 2'd1; a[W +: 2] = 2'd1;
    b = '0; b[1:0] = 2'd1; b[W +: 2] = 2'd2;
    e = '0; e[1:0] = 2'd2;
    do_op(2'd0, a, b, 1'b0, lat, bok, c);
    n_cmp++;
    if (c !== e) begin n_bad++;
      $display("FAIL mul_val: got %h want %h", c, e); end
    n_cmp++;
    if (lat != exp_lat(2'd0)) begin n_bad++;
      $display("FAIL mul_lat: got %0d want %0d", lat, exp_lat(2'd0)); end
    n_cmp++;
    if (!bok) begin n_bad++;
      $display("FAIL mul_busy: got dropped want held"); end
    @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_c !== e) begin n_bad++;
      $display("FAIL mul_after: done=%b busy=%b c=%h want 0/0/%h",
               o_done, o_busy, o_c, e); end
  endtask

  task automatic test_sqr();
    logic [4*M-1:0] a, c, e;
    int lat; bit bok;
    a = '0; a[1:0] = 2'd1; a[W +: 2] = 2'd1;
    e = '0; e[W +: 2] = 2'd2;
    do_op(2'd1, a, rnd_elem(), 1'b0, lat, bok, c);
    n_cmp++;
    if (c !== e || lat != exp_lat(2'd1) || !bok) begin n_bad++;
      $display("FAIL sqr: c=%h lat=%0d busy=%b want %h %0d 1",
               c, lat, bok, e, exp_lat(2'd1)); end
  endtask

  task automatic test_back_to_back();
    logic [4*M-1:0] a, b, c, e;
    int lat; bit bok;
    a = '0; a[1:0] = 2'd1; a[W +: 2] = 2'd1;
    b = '0; b[1:0] = 2'd1; b[W +: 2] = 2'd2;
    do_op(2'd2, a, b, 1'b0, lat, bok, c);
    e = '0; e[1:0] = 2'd2;
    n_cmp++;
    if (c !== e || lat != 1 || !bok) begin n_bad++;
      $display("FAIL add: c=%h lat=%0d busy=%b want %h 1 1",
               c, lat, bok, e); end
    do_op(2'd3, a, b, 1'b0, lat, bok, c);
    e = '0; e[W +: 2] = 2'd2;
    n_cmp++;
    if (c !== e || lat != 1 || !bok) begin n_bad++;
      $display("FAIL sub: c=%h lat=%0d busy=%b want %h 1 1",
               c, lat, bok, e); end
  endtask

  task automatic test_random();
    logic [4*M-1:0] a, b, c, e;
    logic [1:0] op;
    int lat; bit bok;
    for (int i = 0; i < 8; i++) begin
      op = 2'(i % 4);
      a = rnd_elem(); b = rnd_elem();
      e = ext_ref(op, a, b);
      do_op(op, a, b, 1'b0, lat, bok, c);
      n_cmp++;
      if (c !== e) begin n_bad++;
        $display("FAIL rnd_val[%0d] op=%0d: got %h want %h", i, op, c, e); end
      n_cmp++;
      if (lat != exp_lat(op) || !bok) begin n_bad++;
        $display("FAIL rnd_lat[%0d] op=%0d: lat=%0d busy=%b want %0d 1",
                 i, op, lat, bok, exp_lat(op)); end
    end
  endtask

  task automatic test_start_spam();
    logic [4*M-1:0] a, b, c, e;
    int lat; bit bok; bit extra;
    a = rnd_elem(); b = rnd_elem();
    e = ext_ref(2'd0, a, b);
    do_op(2'd0, a, b, 1'b1, lat, bok, c);
    n_cmp++;
    if (c !== e || lat != exp_lat(2'd0) || !bok) begin n_bad++;
      $display("FAIL spam: c=%h lat=%0d busy=%b want %h %0d 1",
               c, lat, bok, e, exp_lat(2'd0)); end
    extra = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_busy !== 1'b0) extra = 1'b1;
    end
    n_cmp++;
    if (extra) begin n_bad++;
      $display("FAIL spam_extra: got activity want idle"); end
  endtask

  task automatic test_reset_mid();
    logic [4*M-1:0] a, c, e;
    int lat; bit bok; bit seen;
    @(negedge clk);
    i_op = 2'd0; i_a = rnd_elem(); i_b = rnd_elem(); i_start = 1'b1;
    seen = 1'b0;
    for (int n = 1; n <= T + 10; n++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done === 1'b1) seen = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_c !== '0) begin n_bad++;
      $display("FAIL abort_rst: busy=%b done=%b c=%h want 0/0/0",
               o_busy, o_done, o_c); end
    for (int n = 0; n < 3 * (T + 2) + 10; n++) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++;
      $display("FAIL abort_done: got activity want none"); end
    a = rnd_elem();
    e = ext_ref(2'd1, a, '0);
    do_op(2'd1, a, rnd_elem(), 1'b0, lat, bok, c);
    n_cmp++;
    if (c !== e || lat != exp_lat(2'd1) || !bok) begin n_bad++;
      $display("FAIL abort_sqr: c=%h lat=%0d busy=%b want %h %0d 1",
               c, lat, bok, e, exp_lat(2'd1)); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_sqr();
    test_back_to_back();
    test_random();
    test_start_spam();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
